// File: rtl/alu_issue_seq.sv
// ============================================================================
// Module      : alu_issue_seq
// Description : Issue/sequencing stage for the 16-bit ripple ALU. Accepts one
//               command per handshake, decodes it onto the ALU control lines,
//               captures the ALU result with locally computed flags, and runs
//               MUL as a 16-step shift-add loop through the ALU adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_in_cmd,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_cin,
  output logic             o_alu_ainvert,
  output logic             o_alu_bnegate,
  output logic [2:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_result,
  output logic             o_out_zero,
  output logic             o_out_carry,
  output logic             o_out_ovf,
  output logic             o_out_err
);

  localparam logic [2:0] c_CMD_AND = 3'd0;
  localparam logic [2:0] c_CMD_OR  = 3'd1;
  localparam logic [2:0] c_CMD_ADD = 3'd2;
  localparam logic [2:0] c_CMD_SUB = 3'd3;
  localparam logic [2:0] c_CMD_SLT = 3'd4;
  localparam logic [2:0] c_CMD_NOR = 3'd5;
  localparam logic [2:0] c_CMD_MUL = 3'd6;

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;

  localparam logic [3:0] c_MUL_LAST = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Latched command and operands
  logic [2:0]       r_cmd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  // Multiply loop state: accumulator, shifted multiplicand, shifted multiplier
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mc;
  logic [WIDTH-1:0] r_mp;
  logic [3:0]       r_cnt;
  logic             r_mul_carry;

  // Captured result and flags
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_carry;
  logic             r_out_ovf;
  logic             r_out_err;

  logic             w_accept;
  logic             w_in_is_mul;
  logic             w_ovf_add;
  logic             w_ovf_sub;
  logic [WIDTH-1:0] w_exec_result;
  logic             w_exec_carry;
  logic             w_exec_ovf;
  logic             w_exec_err;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_mul_carry_next;

  assign w_accept    = i_in_valid & o_in_ready;
  assign w_in_is_mul = (i_in_cmd == c_CMD_MUL) && MUL_EN;

  // MUL step: add the shifted multiplicand only when the current multiplier bit is set
  assign w_acc_next       = r_mp[0] ? i_alu_result : r_acc;
  assign w_mul_carry_next = r_mul_carry | (r_mp[0] & i_alu_cout);

  // Signed overflow of the adder as seen for ADD and for SUB (A + ~B + 1)
  assign w_ovf_add = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (i_alu_result[WIDTH-1] != r_a[WIDTH-1]);
  assign w_ovf_sub = (r_a[WIDTH-1] != r_b[WIDTH-1]) & (i_alu_result[WIDTH-1] != r_a[WIDTH-1]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, handshake ready and ALU control decode
  always_comb begin
    w_state_next  = r_state;
    o_in_ready    = 1'b0;
    o_alu_a       = '0;
    o_alu_b       = '0;
    o_alu_cin     = 1'b0;
    o_alu_ainvert = 1'b0;
    o_alu_bnegate = 1'b0;
    o_alu_op      = c_OP_AND;
    case (r_state)
      S_IDLE: begin
        o_in_ready = rst_n;
        if (i_in_valid) begin
          w_state_next = w_in_is_mul ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_DONE;
        // A MUL reaching EXEC means MUL is disabled, so it falls to the illegal default
        case (r_cmd)
          c_CMD_AND: begin
            o_alu_a = r_a; o_alu_b = r_b;
            o_alu_op = c_OP_AND;
          end
          c_CMD_OR: begin
            o_alu_a = r_a; o_alu_b = r_b;
            o_alu_op = c_OP_OR;
          end
          c_CMD_ADD: begin
            o_alu_a = r_a; o_alu_b = r_b;
            o_alu_op = c_OP_ADD;
          end
          c_CMD_SUB, c_CMD_SLT: begin
            o_alu_a = r_a; o_alu_b = r_b;
            o_alu_bnegate = 1'b1;
            o_alu_cin     = 1'b1;
            o_alu_op      = c_OP_ADD;
          end
          c_CMD_NOR: begin
            o_alu_a = r_a; o_alu_b = r_b;
            o_alu_ainvert = 1'b1;
            o_alu_bnegate = 1'b1;
            o_alu_op      = c_OP_AND;
          end
          default: begin
            o_alu_a = '0;
            o_alu_b = '0;
          end
        endcase
      end
      S_MUL: begin
        o_alu_a  = r_acc;
        o_alu_b  = r_mc;
        o_alu_op = c_OP_ADD;
        if (r_cnt == c_MUL_LAST) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_in_ready = i_out_ready;
        if (i_out_ready) begin
          if (i_in_valid) begin
            w_state_next = w_in_is_mul ? S_MUL : S_EXEC;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result and flag selection for single-cycle commands
  always_comb begin
    w_exec_result = '0;
    w_exec_carry  = 1'b0;
    w_exec_ovf    = 1'b0;
    w_exec_err    = 1'b0;
    case (r_cmd)
      c_CMD_AND, c_CMD_OR, c_CMD_NOR: begin
        w_exec_result = i_alu_result;
      end
      c_CMD_ADD: begin
        w_exec_result = i_alu_result;
        w_exec_carry  = i_alu_cout;
        w_exec_ovf    = w_ovf_add;
      end
      c_CMD_SUB: begin
        w_exec_result = i_alu_result;
        w_exec_carry  = i_alu_cout;
        w_exec_ovf    = w_ovf_sub;
      end
      c_CMD_SLT: begin
        // True signed less-than: difference sign corrected by overflow
        w_exec_result = {{(WIDTH-1){1'b0}}, i_alu_result[WIDTH-1] ^ w_ovf_sub};
      end
      default: begin
        w_exec_err = 1'b1;
      end
    endcase
  end

  // Command latch, multiply loop and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_mc         <= '0;
      r_mp         <= '0;
      r_cnt        <= '0;
      r_mul_carry  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_zero   <= 1'b0;
      r_out_carry  <= 1'b0;
      r_out_ovf    <= 1'b0;
      r_out_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd       <= i_in_cmd;
        r_a         <= i_in_a;
        r_b         <= i_in_b;
        r_acc       <= '0;
        r_mc        <= i_in_a;
        r_mp        <= i_in_b;
        r_cnt       <= '0;
        r_mul_carry <= 1'b0;
      end
      case (r_state)
        S_EXEC: begin
          r_out_valid  <= 1'b1;
          r_out_result <= w_exec_result;
          r_out_zero   <= (w_exec_result == '0);
          r_out_carry  <= w_exec_carry;
          r_out_ovf    <= w_exec_ovf;
          r_out_err    <= w_exec_err;
        end
        S_MUL: begin
          r_acc       <= w_acc_next;
          r_mc        <= r_mc << 1;
          r_mp        <= r_mp >> 1;
          r_cnt       <= r_cnt + 4'd1;
          r_mul_carry <= w_mul_carry_next;
          if (r_cnt == c_MUL_LAST) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_acc_next;
            r_out_zero   <= (w_acc_next == '0);
            r_out_carry  <= w_mul_carry_next;
            r_out_ovf    <= 1'b0;
            r_out_err    <= 1'b0;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_result = r_out_result;
  assign o_out_zero   = r_out_zero;
  assign o_out_carry  = r_out_carry;
  assign o_out_ovf    = r_out_ovf;
  assign o_out_err    = r_out_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_seq.sv
// ============================================================================
// Module      : tb_alu_issue_seq
// Description : Directed self-checking bench for alu_issue_seq, with a
//               behavioural model of the 16-bit ripple ALU closing the loop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_seq;

  localparam logic [2:0] c_AND = 3'd0;
  localparam logic [2:0] c_OR  = 3'd1;
  localparam logic [2:0] c_ADD = 3'd2;
  localparam logic [2:0] c_SUB = 3'd3;
  localparam logic [2:0] c_SLT = 3'd4;
  localparam logic [2:0] c_NOR = 3'd5;
  localparam logic [2:0] c_MUL = 3'd6;
  localparam logic [2:0] c_RSV = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_cmd;
  logic [15:0] in_a, in_b;
  logic [15:0] alu_a, alu_b;
  logic        alu_cin, alu_ainvert, alu_bnegate;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero, out_carry, out_ovf, out_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_cmd     (in_cmd),
    .i_in_a       (in_a),
    .i_in_b       (in_b),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_cin    (alu_cin),
    .o_alu_ainvert(alu_ainvert),
    .o_alu_bnegate(alu_bnegate),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_result),
    .i_alu_cout   (alu_cout),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_result (out_result),
    .o_out_zero   (out_zero),
    .o_out_carry  (out_carry),
    .o_out_ovf    (out_ovf),
    .o_out_err    (out_err)
  );

  // Behavioural 16-bit ALU: optional inversions, then AND / OR / ADD
  logic [15:0] m_a, m_b;
  logic [16:0] m_sum;
  always_comb begin
    m_a   = alu_ainvert ? ~alu_a : alu_a;
    m_b   = alu_bnegate ? ~alu_b : alu_b;
    m_sum = {1'b0, m_a} + {1'b0, m_b} + {16'd0, alu_cin};
    alu_cout = m_sum[16];
    case (alu_op)
      3'b000:  alu_result = m_a & m_b;
      3'b001:  alu_result = m_a | m_b;
      3'b010:  alu_result = m_sum[15:0];
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command while the block is ready and let it be accepted
  task automatic issue(input string tag, input logic [2:0] cmd, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_a     = a;
    in_b     = b;
    chk({tag, ":in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Expect out_valid exactly lat cycles after acceptance, then check result/flags
  task automatic expect_out(input string tag, input int lat, input logic [15:0] res,
                            input logic z, input logic c, input logic o, input logic e);
    for (int i = 0; i < lat; i++) begin
      chk({tag, ":busy_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, ":busy_ready"}, {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk({tag, ":valid"},  {31'd0, out_valid}, 32'd1);
    chk({tag, ":result"}, {16'd0, out_result}, {16'd0, res});
    chk({tag, ":zero"},   {31'd0, out_zero},  {31'd0, z});
    chk({tag, ":carry"},  {31'd0, out_carry}, {31'd0, c});
    chk({tag, ":ovf"},    {31'd0, out_ovf},   {31'd0, o});
    chk({tag, ":err"},    {31'd0, out_err},   {31'd0, e});
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    #1;
    chk({tag, ":ready_follows"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ":valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Directed sequence
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cmd    = 3'd0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b0;

    repeat (2) tick();
    chk("rst:in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst:out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst:result",    {16'd0, out_result}, 32'd0);
    chk("rst:flags",     {28'd0, out_zero, out_carry, out_ovf, out_err}, 32'd0);
    chk("rst:alu",       {alu_a, alu_b}, 32'd0);
    chk("rst:alu_ctl",   {27'd0, alu_cin, alu_ainvert, alu_bnegate, alu_op[1:0]}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle:in_ready", {31'd0, in_ready}, 32'd1);

    // Signed overflow on ADD
    issue("add_ovf", c_ADD, 16'h7FFF, 16'h0001);
    expect_out("add_ovf", 1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    consume("add_ovf");

    // Unsigned wrap on ADD: carry out, no signed overflow
    issue("add_wrap", c_ADD, 16'hFFFF, 16'h0001);
    expect_out("add_wrap", 1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    consume("add_wrap");

    // SUB equal operands: zero, carry=1 (no borrow)
    issue("sub_eq", c_SUB, 16'h0005, 16'h0005);
    expect_out("sub_eq", 1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    consume("sub_eq");

    // SUB signed overflow: 0x8000 - 1 = 0x7FFF, carry set
    issue("sub_ovf", c_SUB, 16'h8000, 16'h0001);
    expect_out("sub_ovf", 1, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0);
    consume("sub_ovf");

    // SLT: -1 < 1 is true, 1 < -1 is false
    issue("slt_t", c_SLT, 16'hFFFF, 16'h0001);
    expect_out("slt_t", 1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("slt_t");
    issue("slt_f", c_SLT, 16'h0001, 16'hFFFF);
    expect_out("slt_f", 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    consume("slt_f");

    // MUL 0x0123 * 0x0045 = 0x4E6F, 16-cycle latency, busy throughout
    issue("mul", c_MUL, 16'h0123, 16'h0045);
    expect_out("mul", 16, 16'h4E6F, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("mul");

    // MUL 0xFFFF * 3 = 0x2FFFD -> 0xFFFD, second accumulate carries out
    issue("mul_c", c_MUL, 16'hFFFF, 16'h0003);
    expect_out("mul_c", 16, 16'hFFFD, 1'b0, 1'b1, 1'b0, 1'b0);
    consume("mul_c");

    // Logic ops; NOR = ~(0xF0F0 | 0xFF00) = 0x000F
    issue("and", c_AND, 16'hF0F0, 16'hFF00);
    expect_out("and", 1, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("and");
    issue("nor", c_NOR, 16'hF0F0, 16'hFF00);
    expect_out("nor", 1, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("nor");

    // Reserved command: zero result, err set, single-cycle latency
    issue("rsv", c_RSV, 16'h1234, 16'h5678);
    expect_out("rsv", 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    consume("rsv");

    // Back-pressure: result held, new command ignored until out_ready
    issue("or", c_OR, 16'h00F0, 16'h0F00);
    expect_out("or", 1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_cmd   = c_ADD;
    in_a     = 16'h0001;
    in_b     = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold:valid",    {31'd0, out_valid}, 32'd1);
      chk("hold:result",   {16'd0, out_result}, 32'h0FF0);
      chk("hold:in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("hs:in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    expect_out("hs_add", 1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("hs_add");

    // Reset during MUL: nothing emitted, ready after release
    issue("mul_rst", c_MUL, 16'h0123, 16'h0045);
    repeat (8) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst:out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst:in_ready",  {31'd0, in_ready}, 32'd0);
    chk("mrst:alu_a",     {16'd0, alu_a}, 32'd0);
    chk("mrst:result",    {16'd0, out_result}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mrst:ready_after", {31'd0, in_ready}, 32'd1);
    chk("mrst:valid_after", {31'd0, out_valid}, 32'd0);
    issue("add_after", c_ADD, 16'h0010, 16'h0020);
    expect_out("add_after", 1, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
    consume("add_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
